// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, imem request, IF/ID register, and
// next-PC selection (jr > jump > branch > sequential) with one-bubble redirect flush.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          OFF_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             jr_control,
  input  logic [15:0]      jr_target,
  input  logic             jump,
  input  logic [11:0]      jump_field,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic [15:0]      ex_pc_plus2,
  output logic [15:0]      imem_addr,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      if_instr,
  output logic [15:0]      if_pc_plus2,
  output logic             if_valid,
  output logic             flush,
  output logic             jr_misalign
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] if_instr_q;
  logic [15:0] if_pc_plus2_q;
  logic        if_valid_q;
  logic        flush_q;
  logic        jr_misalign_q;

  logic        redirect;
  logic [15:0] pc_plus2;
  logic [15:0] off_sext;
  logic [15:0] branch_tgt;
  logic [15:0] redirect_tgt;

  assign pc_plus2   = pc_q + 16'd2;
  assign off_sext   = {{(16-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
  assign branch_tgt = ex_pc_plus2 + {off_sext[14:0], 1'b0};
  assign redirect   = (state_q == FETCH) && (jr_control || jump || branch_taken);

  always_comb begin
    redirect_tgt = branch_tgt;
    if (jr_control) begin
      redirect_tgt = {jr_target[15:1], 1'b0};
    end else if (jump) begin
      redirect_tgt = {ex_pc_plus2[15:13], jump_field, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_instr_q    <= 16'h0000;
      if_pc_plus2_q <= 16'h0000;
      if_valid_q    <= 1'b0;
      flush_q       <= 1'b0;
      jr_misalign_q <= 1'b0;
    end else begin
      flush_q       <= 1'b0;
      jr_misalign_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
        end
        FETCH: begin
          // A redirect wins over stall and discards whatever imem returned this cycle.
          if (redirect) begin
            pc_q          <= redirect_tgt;
            if_valid_q    <= 1'b0;
            flush_q       <= 1'b1;
            jr_misalign_q <= jr_control & jr_target[0];
          end else if (halt) begin
            if_valid_q <= 1'b0;
          end else if (!stall) begin
            if (imem_ready) begin
              if_instr_q    <= imem_rdata;
              if_pc_plus2_q <= pc_plus2;
              if_valid_q    <= 1'b1;
              pc_q          <= pc_plus2;
            end else begin
              if_valid_q <= 1'b0;
            end
          end
          if (halt) begin
            state_q <= HALTED;
          end
        end
        HALTED: begin
          if_valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH);
  assign if_instr    = if_instr_q;
  assign if_pc_plus2 = if_pc_plus2_q;
  assign if_valid    = if_valid_q;
  assign flush       = flush_q;
  assign jr_misalign = jr_misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: zero-wait instruction memory model plus a queue of
// expected IF/ID captures, checked per scenario.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, jr_control, jump, branch_taken;
  logic [15:0] jr_target, ex_pc_plus2;
  logic [11:0] jump_field;
  logic [6:0]  branch_offset;
  logic [15:0] imem_addr, imem_rdata, if_instr, if_pc_plus2;
  logic        imem_req, imem_ready, if_valid, flush, jr_misalign;
  logic        ready_drv;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t e;
  logic [15:0] held;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      default:  return a ^ 16'hC3A5;
    endcase
  endfunction

  assign imem_ready = ready_drv;
  assign imem_rdata = mem_word(imem_addr);

  fetch_pc_unit #(.RESET_PC(16'h0000), .OFF_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
    .jr_control(jr_control), .jr_target(jr_target), .jump(jump),
    .jump_field(jump_field), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .ex_pc_plus2(ex_pc_plus2),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_instr(if_instr), .if_pc_plus2(if_pc_plus2),
    .if_valid(if_valid), .flush(flush), .jr_misalign(jr_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; halt = 0; jr_control = 0; jump = 0; branch_taken = 0;
    jr_target = 16'h0; ex_pc_plus2 = 16'h0; jump_field = 12'h0; branch_offset = 7'h0;
  endtask

  task automatic test_reset();
    rst_n = 0; ready_drv = 1; clear_ctrl();
    repeat (3) tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h want 0000", if_instr); end
    n_cmp++; if (if_pc_plus2 !== 16'h0000) begin n_err++; $display("FAIL rst_pcp2: got %h want 0000", if_pc_plus2); end
    n_cmp++; if (flush !== 1'b0 || jr_misalign !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got %b%b want 00", flush, jr_misalign); end
    rst_n = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", imem_req); end
  endtask

  task automatic test_first_fetch();
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL first_req: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    sb.push_back('{16'h1234, 16'h0002});
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL first_valid%0d: got %b want 1", i, if_valid); end
      e = sb.pop_front();
      n_cmp++; if (if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL first_data%0d: got %h/%h want %h/%h", i, if_instr, if_pc_plus2, e.instr, e.pcp2); end
      if (i == 0) sb.push_back('{16'h5678, 16'h0004});
    end
  endtask

  task automatic test_jr_priority();
    jr_control = 1; jr_target = 16'h00A1; jump = 1; jump_field = 12'h055;
    ex_pc_plus2 = 16'h2000; branch_taken = 1; branch_offset = 7'h05;
    tick();
    n_cmp++; if (imem_addr !== 16'h00A0) begin n_err++; $display("FAIL jr_addr: got %h want 00a0", imem_addr); end
    n_cmp++; if (flush !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL jr_flush: got flush=%b valid=%b want 1/0", flush, if_valid); end
    n_cmp++; if (jr_misalign !== 1'b1) begin n_err++; $display("FAIL jr_misalign: got %b want 1", jr_misalign); end
    clear_ctrl();
    sb.push_back('{mem_word(16'h00A0), 16'h00A2});
    tick();
    n_cmp++; if (flush !== 1'b0 || jr_misalign !== 1'b0) begin n_err++; $display("FAIL jr_pulse_end: got %b%b want 00", flush, jr_misalign); end
    e = sb.pop_front();
    n_cmp++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL jr_target_fetch: got %b %h/%h want 1 %h/%h", if_valid, if_instr, if_pc_plus2, e.instr, e.pcp2); end
  endtask

  task automatic test_branch_under_stall();
    branch_taken = 1; ex_pc_plus2 = 16'h0010; branch_offset = 7'h7D; stall = 1;
    tick();
    n_cmp++; if (imem_addr !== 16'h000A) begin n_err++; $display("FAIL br_addr: got %h want 000a", imem_addr); end
    n_cmp++; if (flush !== 1'b1 || if_valid !== 1'b0 || jr_misalign !== 1'b0) begin n_err++; $display("FAIL br_flush: got %b%b%b want 100", flush, if_valid, jr_misalign); end
    clear_ctrl();
    sb.push_back('{mem_word(16'h000A), 16'h000C});
    tick();
    e = sb.pop_front();
    n_cmp++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL br_fetch: got %b %h/%h want 1 %h/%h", if_valid, if_instr, if_pc_plus2, e.instr, e.pcp2); end
    n_cmp++; if (imem_addr !== 16'h000C) begin n_err++; $display("FAIL br_next: got %h want 000c", imem_addr); end
  endtask

  task automatic test_jump_wrap();
    jump = 1; jump_field = 12'hFFF; ex_pc_plus2 = 16'hE002;
    tick();
    n_cmp++; if (imem_addr !== 16'hFFFE || flush !== 1'b1) begin n_err++; $display("FAIL jmp_addr: got %h flush=%b want fffe 1", imem_addr, flush); end
    clear_ctrl();
    sb.push_back('{mem_word(16'hFFFE), 16'h0000});
    tick();
    e = sb.pop_front();
    n_cmp++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL wrap_fetch: got %b %h/%h want 1 %h/%h", if_valid, if_instr, if_pc_plus2, e.instr, e.pcp2); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
  endtask

  task automatic test_stall_and_bubble();
    held = mem_word(16'hFFFE);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_addr !== 16'h0000 || if_instr !== held || if_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d: got %h %h %b want 0000 %h 1", i, imem_addr, if_instr, if_valid, held); end
    end
    stall = 0; ready_drv = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL bubble%0d: got valid=%b addr=%h want 0 0000", i, if_valid, imem_addr); end
    end
    ready_drv = 1;
    sb.push_back('{16'h1234, 16'h0002});
    tick();
    e = sb.pop_front();
    n_cmp++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL resume: got %b %h/%h want 1 %h/%h", if_valid, if_instr, if_pc_plus2, e.instr, e.pcp2); end
  endtask

  task automatic test_halt();
    halt = 1;
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt: got req=%b valid=%b want 0/0", imem_req, if_valid); end
    halt = 0; jump = 1; jump_field = 12'h100; jr_control = 1; jr_target = 16'h0041; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 16'h0002 || flush !== 1'b0 || if_valid !== 1'b0 || jr_misalign !== 1'b0) begin n_err++; $display("FAIL halted%0d: got req=%b addr=%h flush=%b valid=%b mis=%b want 0 0002 0 0 0", i, imem_req, imem_addr, flush, if_valid, jr_misalign); end
    end
    clear_ctrl();
  endtask

  task automatic test_mid_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    sb.push_back('{16'h1234, 16'h0002});
    tick();
    sb.push_back('{16'h5678, 16'h0004});
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      e = sb.pop_front();
      n_cmp++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc_plus2 !== e.pcp2) begin n_err++; $display("FAIL refetch%0d: got %b %h/%h want 1 %h/%h", i, if_valid, if_instr, if_pc_plus2, e.instr, e.pcp2); end
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || if_valid !== 1'b0 || if_instr !== 16'h0000) begin n_err++; $display("FAIL async_rst: got req=%b addr=%h valid=%b instr=%h want 0 0000 0 0000", imem_req, imem_addr, if_valid, if_instr); end
    tick();
    rst_n = 1;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL post_rst_req: got %b %h want 1 0000", imem_req, imem_addr); end
  endtask

  task automatic test_halt_with_redirect();
    halt = 1; jr_control = 1; jr_target = 16'h0301;
    tick();
    n_cmp++; if (imem_addr !== 16'h0300 || imem_req !== 1'b0) begin n_err++; $display("FAIL halt_redir: got addr=%h req=%b want 0300 0", imem_addr, imem_req); end
    n_cmp++; if (flush !== 1'b1 || jr_misalign !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt_redir_pulse: got %b%b%b want 110", flush, jr_misalign, if_valid); end
    clear_ctrl();
    jump = 1; jump_field = 12'h007; branch_taken = 1; branch_offset = 7'h04;
    tick();
    n_cmp++; if (imem_addr !== 16'h0300 || flush !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL halt_hold: got addr=%h flush=%b req=%b want 0300 0 0", imem_addr, flush, imem_req); end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jr_priority();
    test_branch_under_stall();
    test_jump_wrap();
    test_stall_and_bubble();
    test_halt();
    test_mid_reset();
    test_halt_with_redirect();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
